// File: rtl/branch_resolve.sv
// ID-stage branch resolver: decodes B/BL/B.cond/CBZ/BR, forwards EX flags,
// stalls register-operand branches until their operand is final, and registers the decision.
module branch_resolve (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic [63:0] pc_id,
    input  logic        ex_setFlags,
    input  logic        ex_negative,
    input  logic        ex_zero,
    input  logic        ex_overflow,
    input  logic        ex_carry,
    input  logic [63:0] rt_data,
    input  logic        rt_valid,
    output logic        brTaken,
    output logic        uncondBr,
    output logic        BR,
    output logic [63:0] rData,
    output logic        stall,
    output logic        link_we,
    output logic [63:0] link_addr
);

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_OP = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  flags_q;
    logic [3:0]  flagsEff;

    logic        brTaken_q, brTaken_d;
    logic        uncondBr_q, uncondBr_d;
    logic        br_q, br_d;
    logic [63:0] rData_q, rData_d;
    logic        linkWe_q, linkWe_d;
    logic [63:0] linkAddr_q, linkAddr_d;

    logic        isB, isBL, isCbz, isBcond, isBr;
    logic        needOp;
    logic        condMet;
    logic        stallRaw;
    logic        resolve;
    logic        fire;
    logic        unused_ok;

    assign isB     = (instr[31:26] == 6'b000101);
    assign isBL    = (instr[31:26] == 6'b100101);
    assign isCbz   = (instr[31:24] == 8'b10110100);
    assign isBcond = (instr[31:24] == 8'b01010100);
    assign isBr    = (instr[31:21] == 11'b11010110000);

    assign needOp   = instr_valid & (isCbz | isBr);
    // Flags produced in EX this cycle win over the stored copy.
    assign flagsEff = ex_setFlags ? {ex_negative, ex_zero, ex_overflow, ex_carry} : flags_q;
    assign unused_ok = ^{instr[20:4], flagsEff[0]};

    always_comb begin
        condMet = 1'b0;
        case (instr[3:0])
            4'h0:    condMet = flagsEff[2];
            4'h1:    condMet = ~flagsEff[2];
            4'hA:    condMet = (flagsEff[3] == flagsEff[1]);
            4'hB:    condMet = (flagsEff[3] != flagsEff[1]);
            default: condMet = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (needOp && !rt_valid) state_d = WAIT_OP;
            WAIT_OP: if (rt_valid)            state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // The held instruction is resolved either directly in RUN or when the operand arrives.
    always_comb begin
        stallRaw = 1'b0;
        resolve  = 1'b0;
        case (state_q)
            RUN: begin
                stallRaw = needOp & ~rt_valid;
                resolve  = ~stallRaw;
            end
            WAIT_OP: begin
                stallRaw = ~rt_valid;
                resolve  = rt_valid;
            end
            default: begin
                stallRaw = 1'b0;
                resolve  = 1'b0;
            end
        endcase
        stall = stallRaw & reset;

        fire       = resolve & instr_valid;
        brTaken_d  = fire & (isB | isBL | (isBcond & condMet) | (isCbz & (rt_data == 64'd0)));
        uncondBr_d = fire & (isB | isBL);
        br_d       = fire & isBr;
        rData_d    = br_d ? rt_data : 64'd0;
        linkWe_d   = fire & isBL;
        linkAddr_d = linkWe_d ? (pc_id + 64'd4) : 64'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q    <= 4'b0000;
            brTaken_q  <= 1'b0;
            uncondBr_q <= 1'b0;
            br_q       <= 1'b0;
            rData_q    <= 64'd0;
            linkWe_q   <= 1'b0;
            linkAddr_q <= 64'd0;
        end else begin
            if (ex_setFlags) begin
                flags_q <= {ex_negative, ex_zero, ex_overflow, ex_carry};
            end
            brTaken_q  <= brTaken_d;
            uncondBr_q <= uncondBr_d;
            br_q       <= br_d;
            rData_q    <= rData_d;
            linkWe_q   <= linkWe_d;
            linkAddr_q <= linkAddr_d;
        end
    end

    assign brTaken   = brTaken_q;
    assign uncondBr  = uncondBr_q;
    assign BR        = br_q;
    assign rData     = rData_q;
    assign link_we   = linkWe_q;
    assign link_addr = linkAddr_q;

endmodule
